// File: rtl/division_unit.sv
// division_unit: sequential restoring shift-subtract divider (unsigned).
//   A Start pulse seen in IDLE latches Dividend/Divisor. The unit then produces
//   one quotient bit per clock and publishes Quotient/Remainder/DivByZero
//   together with a one-cycle Done strobe.
// Ports:
//   clock      - system clock, rising edge
//   reset      - synchronous, active-high
//   Start      - request, only looked at in IDLE
//   Dividend   - unsigned dividend, WIDTH bits
//   Divisor    - unsigned divisor, WIDTH bits
//   Quotient   - registered quotient, written on DONE entry
//   Remainder  - registered remainder, written on DONE entry
//   Busy       - high while in RUN or DONE
//   Done       - high for exactly the one DONE cycle
//   DivByZero  - registered divide-by-zero flag, written with the results
module division_unit #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             Start,
    input  logic [WIDTH-1:0] Dividend,
    input  logic [WIDTH-1:0] Divisor,
    output logic [WIDTH-1:0] Quotient,
    output logic [WIDTH-1:0] Remainder,
    output logic             Busy,
    output logic             Done,
    output logic             DivByZero
);

    localparam int unsigned CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] q_reg;
    logic [WIDTH-1:0] m_reg;
    logic [CNT_W-1:0] cnt;

    logic [WIDTH:0]   a_shift;
    logic [WIDTH:0]   trial;
    logic             accept;
    logic [WIDTH-1:0] a_next;
    logic [WIDTH-1:0] q_next;

    // One restoring step. a_shift keeps the bit shifted out of A, so the trial
    // subtraction is WIDTH+1 bits and its MSB is the borrow. A restored
    // remainder is always below M, so it fits back into WIDTH bits.
    always_comb begin
        a_shift = {a_reg, q_reg[WIDTH-1]};
        trial   = a_shift - {1'b0, m_reg};
        accept  = ~trial[WIDTH];
        a_next  = accept ? trial[WIDTH-1:0] : a_shift[WIDTH-1:0];
        q_next  = {q_reg[WIDTH-2:0], accept};
    end

    // Control FSM and datapath registers; all outputs are registered here.
    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= S_IDLE;
            a_reg     <= '0;
            q_reg     <= '0;
            m_reg     <= '0;
            cnt       <= '0;
            Quotient  <= '0;
            Remainder <= '0;
            Busy      <= 1'b0;
            Done      <= 1'b0;
            DivByZero <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (Start) begin
                        Busy <= 1'b1;
                        if (Divisor != '0) begin
                            m_reg <= Divisor;
                            q_reg <= Dividend;
                            a_reg <= '0;
                            cnt   <= CNT_LAST;
                            state <= S_RUN;
                        end else begin
                            // Divide by zero skips the iterations entirely.
                            Quotient  <= '1;
                            Remainder <= Dividend;
                            DivByZero <= 1'b1;
                            Done      <= 1'b1;
                            state     <= S_DONE;
                        end
                    end
                end
                S_RUN: begin
                    a_reg <= a_next;
                    q_reg <= q_next;
                    if (cnt == '0) begin
                        Quotient  <= q_next;
                        Remainder <= a_next;
                        DivByZero <= 1'b0;
                        Done      <= 1'b1;
                        state     <= S_DONE;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                S_DONE: begin
                    Busy  <= 1'b0;
                    Done  <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    Busy  <= 1'b0;
                    Done  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
